iq_wakeup_select: RTL and testbench

- Issue-queue wakeup/select stage; sits directly downstream of the 6-read/4-write tag CAMs.
- One CAM per source operand holds the physical source tags of each queue entry. Six result-tag broadcasts per cycle are searched in each CAM. This block consumes the resulting match vectors.
- Per entry it maintains valid/ready state, sets operand ready bits on valid matches, and selects up to two fully-ready entries per cycle for issue, lowest index first.
- Dispatch writes use the same four write ports and addresses as the CAM writes.

---
 rtl/iq_wakeup_select.sv | 127 ++++++++++++
 tb/tb_iq_wakeup_select.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iq_wakeup_select.sv
// Issue-queue wakeup/select: tracks per-entry valid/ready state, wakes operands from CAM match vectors,
// and grants up to two ready entries per cycle, lowest index first. Grants are combinational from registered state.
module iq_wakeup_select #(
  parameter int IQ_DEPTH = 16,
  parameter int IQ_INDEX = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 disp_we_i,
  input  logic [4*IQ_INDEX-1:0]      disp_addr_i,
  input  logic [3:0]                 disp_rdy1_i,
  input  logic [3:0]                 disp_rdy2_i,
  input  logic [5:0]                 bcast_valid_i,
  input  logic [6*IQ_DEPTH-1:0]      src1_match_i,
  input  logic [6*IQ_DEPTH-1:0]      src2_match_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       grant0_valid_o,
  output logic [IQ_INDEX-1:0]        grant0_idx_o,
  output logic                       grant1_valid_o,
  output logic [IQ_INDEX-1:0]        grant1_idx_o,
  output logic [IQ_INDEX:0]          free_cnt_o,
  output logic                       error_o
);

  logic [IQ_DEPTH-1:0] valid, rdy1, rdy2, req;
  logic [IQ_DEPTH-1:0] wake1, wake2, issue_mask;
  logic [IQ_DEPTH-1:0] disp_hit, disp_r1, disp_r2;
  logic [IQ_DEPTH-1:0] valid_n, rdy1_n, rdy2_n;
  logic [IQ_INDEX:0]   free_n;
  logic                disp_err;
  logic                g0_found, g1_found, grant_en;
  logic [IQ_INDEX-1:0] g0_idx, g1_idx;

  assign req      = valid & rdy1 & rdy2;
  assign grant_en = ~stall_i & ~flush_i;

  always_comb begin
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (req[i]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = IQ_INDEX'(i);
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = IQ_INDEX'(i);
        end
      end
    end
  end

  assign grant0_valid_o = g0_found & grant_en;
  assign grant1_valid_o = g1_found & grant_en;
  assign grant0_idx_o   = grant0_valid_o ? g0_idx : '0;
  assign grant1_idx_o   = grant1_valid_o ? g1_idx : '0;

  always_comb begin
    issue_mask = '0;
    if (grant0_valid_o) issue_mask[g0_idx] = 1'b1;
    if (grant1_valid_o) issue_mask[g1_idx] = 1'b1;
  end

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      for (int k = 0; k < 6; k++) begin
        wake1[i] = wake1[i] | (bcast_valid_i[k] & src1_match_i[k*IQ_DEPTH+i]);
        wake2[i] = wake2[i] | (bcast_valid_i[k] & src2_match_i[k*IQ_DEPTH+i]);
      end
    end
  end

  // Ports are walked in ascending order so the highest-numbered port wins a duplicate address.
  always_comb begin
    disp_hit = '0;
    disp_r1  = '0;
    disp_r2  = '0;
    disp_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (disp_we_i[k]) begin
        if (valid[disp_addr_i[k*IQ_INDEX +: IQ_INDEX]]) disp_err = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (disp_we_i[j] &&
              disp_addr_i[j*IQ_INDEX +: IQ_INDEX] == disp_addr_i[k*IQ_INDEX +: IQ_INDEX])
            disp_err = 1'b1;
        end
        disp_hit[disp_addr_i[k*IQ_INDEX +: IQ_INDEX]] = 1'b1;
        disp_r1[disp_addr_i[k*IQ_INDEX +: IQ_INDEX]]  = disp_rdy1_i[k];
        disp_r2[disp_addr_i[k*IQ_INDEX +: IQ_INDEX]]  = disp_rdy2_i[k];
      end
    end
  end

  // Dispatch overrides both issue and wakeup; a match on the written index is for the stale tag.
  always_comb begin
    valid_n = (valid & ~issue_mask) | disp_hit;
    rdy1_n  = ((rdy1 | (wake1 & valid)) & ~disp_hit) | (disp_r1 & disp_hit);
    rdy2_n  = ((rdy2 | (wake2 & valid)) & ~disp_hit) | (disp_r2 & disp_hit);
    if (flush_i) valid_n = '0;
    free_n = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      free_n = free_n + {{IQ_INDEX{1'b0}}, ~valid_n[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      rdy1       <= '0;
      rdy2       <= '0;
      free_cnt_o <= (IQ_INDEX+1)'(IQ_DEPTH);
      error_o    <= 1'b0;
    end else begin
      valid      <= valid_n;
      rdy1       <= rdy1_n;
      rdy2       <= rdy2_n;
      free_cnt_o <= free_n;
      // Dispatches squashed by a flush never write, so they are not treated as protocol errors.
      if (disp_err && !flush_i) error_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_wakeup_select.sv
// Bench for iq_wakeup_select: cycle vectors of inputs plus expected outputs, checked via a scoreboard queue.
module tb_iq_wakeup_select;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  disp_we_i, disp_rdy1_i, disp_rdy2_i;
  logic [15:0] disp_addr_i;
  logic [5:0]  bcast_valid_i;
  logic [95:0] src1_match_i, src2_match_i;
  logic        stall_i, flush_i;
  logic        grant0_valid_o, grant1_valid_o, error_o;
  logic [3:0]  grant0_idx_o, grant1_idx_o;
  logic [4:0]  free_cnt_o;

  iq_wakeup_select #(.IQ_DEPTH(16), .IQ_INDEX(4)) dut (
    .clk(clk), .reset(reset),
    .disp_we_i(disp_we_i), .disp_addr_i(disp_addr_i),
    .disp_rdy1_i(disp_rdy1_i), .disp_rdy2_i(disp_rdy2_i),
    .bcast_valid_i(bcast_valid_i), .src1_match_i(src1_match_i), .src2_match_i(src2_match_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .grant0_valid_o(grant0_valid_o), .grant0_idx_o(grant0_idx_o),
    .grant1_valid_o(grant1_valid_o), .grant1_idx_o(grant1_idx_o),
    .free_cnt_o(free_cnt_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       g0v;
    logic [3:0] g0i;
    logic       g1v;
    logic [3:0] g1i;
    logic [4:0] fc;
    logic       er;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [3:0]  r1, r2;
    logic [5:0]  bv;
    logic [95:0] m1, m2;
    logic        st, fl;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] we, input logic [15:0] addr,
                              input logic [3:0] r1, input logic [3:0] r2, input logic [5:0] bv,
                              input logic [95:0] m1, input logic [95:0] m2,
                              input logic st, input logic fl,
                              input logic g0v, input logic [3:0] g0i,
                              input logic g1v, input logic [3:0] g1i,
                              input logic [4:0] fc, input logic er);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.r1 = r1; v.r2 = r2; v.bv = bv;
    v.m1 = m1; v.m2 = m2; v.st = st; v.fl = fl;
    v.e.g0v = g0v; v.e.g0i = g0i; v.e.g1v = g1v; v.e.g1i = g1i; v.e.fc = fc; v.e.er = er;
    return v;
  endfunction

  function automatic vec_t idle(input logic g0v, input logic [3:0] g0i,
                                input logic g1v, input logic [3:0] g1i,
                                input logic [4:0] fc, input logic er);
    return mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 0, 0, g0v, g0i, g1v, g1i, fc, er);
  endfunction

  function automatic logic [95:0] bit96(input int n);
    logic [95:0] one;
    one = 96'd1;
    return one << n;
  endfunction

  task automatic chk(input int row, input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL row%0d %s: got %0d, expected %0d", row, name, got, want);
    end
  endtask

  task automatic apply(input int row, input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; disp_we_i = v.we; disp_addr_i = v.addr;
    disp_rdy1_i = v.r1; disp_rdy2_i = v.r2; bcast_valid_i = v.bv;
    src1_match_i = v.m1; src2_match_i = v.m2; stall_i = v.st; flush_i = v.fl;
    sb.push_back(v.e);
    #1;
    e = sb.pop_front();
    chk(row, "grant0_valid", int'(grant0_valid_o), int'(e.g0v));
    chk(row, "grant0_idx",   int'(grant0_idx_o),   int'(e.g0i));
    chk(row, "grant1_valid", int'(grant1_valid_o), int'(e.g1v));
    chk(row, "grant1_idx",   int'(grant1_idx_o),   int'(e.g1i));
    chk(row, "free_cnt",     int'(free_cnt_o),     int'(e.fc));
    chk(row, "error",        int'(error_o),        int'(e.er));
  endtask

  initial begin
    // Each row: inputs driven for one cycle; expectations are outputs seen before that cycle's edge.
    for (int i = 0; i < 5; i++) tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0011, 16'h0073, 4'b0011, 4'b0011, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(idle(1, 3, 1, 7, 14, 0));
    tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    // src2 wakeup from broadcast 2
    tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b000100, 96'b0, bit96(37), 0, 0, 0, 0, 0, 0, 15, 0));
    tbl.push_back(idle(1, 5, 0, 0, 15, 0));
    tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    // same match with the broadcast invalid: no wakeup
    tbl.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 4'b0000, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b000000, 96'b0, bit96(37), 0, 0, 0, 0, 0, 0, 15, 0));
    tbl.push_back(idle(0, 0, 0, 0, 15, 0));
    tbl.push_back(mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b000001, 96'b0, bit96(5), 0, 0, 0, 0, 0, 0, 15, 0));
    tbl.push_back(idle(1, 5, 0, 0, 15, 0));
    tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    // stall holds entries 1, 2, 4
    tbl.push_back(mk(0, 4'b0111, 16'h0421, 4'b0111, 4'b0111, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 1, 0, 0, 0, 0, 0, 13, 0));
    tbl.push_back(mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 1, 0, 0, 0, 0, 0, 13, 0));
    tbl.push_back(idle(1, 1, 1, 2, 13, 0));
    tbl.push_back(idle(1, 4, 0, 0, 15, 0));
    tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    // stale same-cycle match on a dispatched entry is ignored; later src1 wakeup via broadcast 5
    tbl.push_back(mk(0, 4'b0001, 16'h0006, 4'b0000, 4'b0001, 6'b000010, bit96(22), 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(idle(0, 0, 0, 0, 15, 0));
    tbl.push_back(mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b100000, bit96(86), 96'b0, 0, 0, 0, 0, 0, 0, 15, 0));
    tbl.push_back(idle(1, 6, 0, 0, 15, 0));
    // both operands woken by different broadcasts in one cycle
    tbl.push_back(mk(0, 4'b0001, 16'h000A, 4'b0000, 4'b0000, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(idle(0, 0, 0, 0, 15, 0));
    tbl.push_back(mk(0, 4'b0, 16'h0, 4'b0, 4'b0, 6'b000011, bit96(10), bit96(26), 0, 0, 0, 0, 0, 0, 15, 0));
    tbl.push_back(idle(1, 10, 0, 0, 15, 0));
    tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    // eight valid entries, then flush with a simultaneous dispatch to entry 0
    tbl.push_back(mk(0, 4'b1111, 16'hBA98, 4'b1111, 4'b1111, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(mk(0, 4'b1111, 16'hFEDC, 4'b1111, 4'b1111, 6'b0, 96'b0, 96'b0, 1, 0, 0, 0, 0, 0, 12, 0));
    tbl.push_back(mk(0, 4'b0001, 16'h0000, 4'b0001, 4'b0001, 6'b0, 96'b0, 96'b0, 0, 1, 0, 0, 0, 0, 8, 0));
    tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    tbl.push_back(idle(0, 0, 0, 0, 16, 0));
    // fill the queue with non-ready entries, then dispatch into the full queue
    tbl.push_back(mk(0, 4'b1111, 16'h3210, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    tbl.push_back(mk(0, 4'b1111, 16'h7654, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 12, 0));
    tbl.push_back(mk(0, 4'b1111, 16'hBA98, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 8, 0));
    tbl.push_back(mk(0, 4'b1111, 16'hFEDC, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 4, 0));
    tbl.push_back(idle(0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 16'h9000, 4'b1000, 4'b1000, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 9, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 0, 0, 1, 1));
    tbl.push_back(idle(0, 0, 0, 0, 1, 1));

    reset = 1'b1; disp_we_i = '0; disp_addr_i = '0; disp_rdy1_i = '0; disp_rdy2_i = '0;
    bcast_valid_i = '0; src1_match_i = '0; src2_match_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int r = 0; r < tbl.size(); r++) apply(r, tbl[r]);

    // reset overrides a same-cycle dispatch and clears the sticky error
    apply(100, mk(1, 4'b0001, 16'h0003, 4'b0001, 4'b0001, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 1, 1));
    apply(101, idle(0, 0, 0, 0, 16, 0));
    apply(102, idle(0, 0, 0, 0, 16, 0));

    // dispatch into an entry that is being granted in the same cycle
    apply(110, mk(0, 4'b0001, 16'h0003, 4'b0001, 4'b0001, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    apply(111, mk(0, 4'b0001, 16'h0003, 4'b0000, 4'b0000, 6'b0, 96'b0, 96'b0, 0, 0, 1, 3, 0, 0, 15, 0));
    apply(112, idle(0, 0, 0, 0, 15, 1));
    apply(113, mk(1, 4'b0, 16'h0, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 15, 1));
    apply(114, idle(0, 0, 0, 0, 16, 0));

    // ports 0 and 2 both target entry 9; port 2's ready flags must win
    apply(120, mk(0, 4'b0101, 16'h0909, 4'b0100, 4'b0101, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 0));
    apply(121, idle(1, 9, 0, 0, 15, 1));
    apply(122, idle(0, 0, 0, 0, 16, 1));
    apply(123, idle(0, 0, 0, 0, 16, 1));
    apply(124, mk(1, 4'b0, 16'h0, 4'b0, 4'b0, 6'b0, 96'b0, 96'b0, 0, 0, 0, 0, 0, 0, 16, 1));
    apply(125, idle(0, 0, 0, 0, 16, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
